// File: rtl/fifo_read_ctrl.sv
// ============================================================================
//  Module   : fifo_read_ctrl
//  Purpose  : Read-side pop pacer for the async FIFO, feeding a 2-entry
//             valid/ready output buffer. Optional macro: FIFO_RD_STATS_EN
//             (adds rd_count / stall_count statistics).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_read_ctrl #(
   parameter int DSIZE  = 8,
   parameter int RD_GAP = 2,
   parameter int CNT_W  = 16
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             en,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [DSIZE-1:0] m_data
`ifdef FIFO_RD_STATS_EN
   ,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] stall_count
`endif
);

   localparam int c_GAP_W = (RD_GAP > 2) ? $clog2(RD_GAP) : 1;
   localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'((RD_GAP > 0) ? RD_GAP - 1 : 0);

   typedef enum logic [0:0] {
      ST_WAIT = 1'b0,
      ST_GAP  = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_GAP_W-1:0]   r_gap_cnt;
   logic [c_GAP_W-1:0]   w_gap_nxt;
   logic                 w_pop;
   logic                 w_drain;
   logic [1:0]           r_count;
   logic [DSIZE-1:0]     r_buf0;
   logic [DSIZE-1:0]     r_buf1;

   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_state   <= ST_WAIT;
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_gap_cnt <= w_gap_nxt;
      end
   end

   // Pop decision uses only registered occupancy, never m_ready.
   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap_cnt;
      w_pop       = 1'b0;
      case (r_state)
         ST_WAIT: begin
            w_pop = ~rrst & en & ~rempty & (r_count != 2'd2);
            if (w_pop && (RD_GAP > 0)) begin
               w_state_nxt = ST_GAP;
               w_gap_nxt   = c_GAP_LOAD;
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == '0) begin
               w_state_nxt = ST_WAIT;
            end else begin
               w_gap_nxt = r_gap_cnt - c_GAP_W'(1);
            end
         end
         default: w_state_nxt = ST_WAIT;
      endcase
   end

   assign rinc    = w_pop;
   assign m_valid = (r_count != 2'd0);
   assign m_data  = r_buf0;
   assign w_drain = m_valid & m_ready;

   // Head stays put when the last word drains so m_data holds its last value.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_count <= 2'd0;
         r_buf0  <= '0;
         r_buf1  <= '0;
      end else begin
         case ({w_pop, w_drain})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_buf0 <= rdata;
               end else begin
                  r_buf1 <= rdata;
               end
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               if (r_count == 2'd2) begin
                  r_buf0 <= r_buf1;
               end
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_buf0 <= rdata;
               end else begin
                  r_buf0 <= r_buf1;
                  r_buf1 <= rdata;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef FIFO_RD_STATS_EN
   always_ff @(posedge rclk) begin
      if (rrst) begin
         rd_count    <= '0;
         stall_count <= '0;
      end else begin
         if (w_pop) begin
            rd_count <= rd_count + CNT_W'(1);
         end
         if ((r_state == ST_WAIT) && en && rempty) begin
            stall_count <= stall_count + CNT_W'(1);
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
// ============================================================================
//  Module   : tb_fifo_read_ctrl
//  Purpose  : Directed bench for fifo_read_ctrl with RD_GAP=2 and RD_GAP=0
//             instances, each fed by a small FIFO model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_read_ctrl;

   logic       r_clk;
   logic       r_rst;
   logic       r_en;
   logic       r_hold_empty;
   logic       r_m_ready_a;
   logic       r_m_ready_b;

   logic [7:0] r_mem_a [0:511];
   logic [7:0] r_mem_b [0:511];
   int         r_head_a = 0;
   int         r_tail_a = 0;
   int         r_head_b = 0;
   int         r_tail_b = 0;
   int         r_exp_a  = 0;
   int         r_exp_b  = 0;

   int         n_chk = 0;
   int         n_err = 0;

   logic       w_rempty_a, w_rempty_b;
   logic [7:0] w_rdata_a, w_rdata_b;
   logic       w_rinc_a, w_rinc_b;
   logic       w_m_valid_a, w_m_valid_b;
   logic [7:0] w_m_data_a, w_m_data_b;
`ifdef FIFO_RD_STATS_EN
   logic [15:0] w_rd_count_a, w_stall_count_a;
   logic [15:0] w_rd_count_b, w_stall_count_b;
`endif

   localparam logic [7:0] c_PRE_A [0:15] = '{
      8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E,
      8'h11, 8'hEE, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

   assign w_rempty_a = (r_head_a == r_tail_a) | r_hold_empty;
   assign w_rempty_b = (r_head_b == r_tail_b) | r_hold_empty;
   assign w_rdata_a  = r_mem_a[r_head_a];
   assign w_rdata_b  = r_mem_b[r_head_b];

   fifo_read_ctrl #(.DSIZE(8), .RD_GAP(2), .CNT_W(16)) u_gap2 (
      .rclk(r_clk), .rrst(r_rst), .en(r_en), .rempty(w_rempty_a),
      .rdata(w_rdata_a), .rinc(w_rinc_a), .m_valid(w_m_valid_a),
      .m_ready(r_m_ready_a), .m_data(w_m_data_a)
`ifdef FIFO_RD_STATS_EN
      , .rd_count(w_rd_count_a), .stall_count(w_stall_count_a)
`endif
   );

   fifo_read_ctrl #(.DSIZE(8), .RD_GAP(0), .CNT_W(16)) u_gap0 (
      .rclk(r_clk), .rrst(r_rst), .en(r_en), .rempty(w_rempty_b),
      .rdata(w_rdata_b), .rinc(w_rinc_b), .m_valid(w_m_valid_b),
      .m_ready(r_m_ready_b), .m_data(w_m_data_b)
`ifdef FIFO_RD_STATS_EN
      , .rd_count(w_rd_count_b), .stall_count(w_stall_count_b)
`endif
   );

   initial r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // FIFO model: head advances on every pop strobe
   always @(posedge r_clk) begin
      if (w_rinc_a) r_head_a <= r_head_a + 1;
      if (w_rinc_b) r_head_b <= r_head_b + 1;
   end

   // Output scoreboard; after a reset the next word out is the FIFO head
   always @(negedge r_clk) begin
      if (r_rst) begin
         r_exp_a = r_head_a;
         r_exp_b = r_head_b;
      end else begin
         if (w_m_valid_a && r_m_ready_a) begin
            check("order_a", 32'(w_m_data_a), 32'(r_mem_a[r_exp_a]));
            r_exp_a++;
         end
         if (w_m_valid_b && r_m_ready_b) begin
            check("order_b", 32'(w_m_data_b), 32'(r_mem_b[r_exp_b]));
            r_exp_b++;
         end
         if (w_rinc_a) check("underflow_a", 32'(w_rempty_a), 32'(0));
         if (w_rinc_b) check("underflow_b", 32'(w_rempty_b), 32'(0));
      end
   end

   initial begin
      r_rst = 1'b1; r_en = 1'b1; r_hold_empty = 1'b0;
      r_m_ready_a = 1'b1; r_m_ready_b = 1'b0;
      for (int i = 0; i < 512; i++) begin
         r_mem_a[i] = 8'h00;
         r_mem_b[i] = 8'h00;
      end
      for (int i = 0; i < 10; i++) r_mem_a[i] = c_PRE_A[i];
      for (int i = 0; i < 5; i++)  r_mem_b[i] = 8'(8'h01 + i);
      r_tail_a = 10;
      r_tail_b = 5;

      // Reset held with data available: nothing may pop or appear
      @(posedge r_clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge r_clk);
         check("rst_rinc_a",   32'(w_rinc_a),    32'(0));
         check("rst_valid_a",  32'(w_m_valid_a), 32'(0));
         check("rst_data_a",   32'(w_m_data_a),  32'(0));
         check("rst_rinc_b",   32'(w_rinc_b),    32'(0));
         check("rst_valid_b",  32'(w_m_valid_b), 32'(0));
      end
      @(posedge r_clk); #1 r_rst = 1'b0;

      // Pacing (gap 2) and backpressure (gap 0, m_ready low)
      for (int c = 0; c < 30; c++) begin
         @(negedge r_clk);
         check("pace_rinc_a", 32'(w_rinc_a), 32'((c % 3 == 0) && (c <= 27)));
         check("bp_rinc_b",   32'(w_rinc_b), 32'(c < 2));
      end
      #1;
      check("pace_count_a", 32'(r_exp_a), 32'(10));
      check("pace_idle_a",  32'(w_m_valid_a), 32'(0));
      check("bp_valid_b",   32'(w_m_valid_b), 32'(1));
      check("bp_head_b",    32'(w_m_data_b),  32'(8'h01));
      check("bp_fifo_b",    32'(r_head_b),    32'(2));
      @(posedge r_clk); #1 r_m_ready_b = 1'b1;
      repeat (8) @(negedge r_clk);
      #1;
      check("bp_count_b", 32'(r_exp_b), 32'(5));
      check("bp_idle_b",  32'(w_m_valid_b), 32'(0));

      // Empty handling: rempty forced for 7 WAIT cycles, en dropped afterwards
      @(posedge r_clk); #1 r_rst = 1'b1;
      for (int i = 10; i < 16; i++) r_mem_a[i] = c_PRE_A[i];
      r_tail_a = 16;
      @(posedge r_clk); #1 r_rst = 1'b0;
      for (int c = 0; c < 24; c++) begin
         if (c > 0) begin
            @(posedge r_clk); #1;
         end
         r_hold_empty = (c >= 3) && (c <= 9);
         r_en = (c < 23);
         @(negedge r_clk);
         check("empty_rinc_a", 32'(w_rinc_a),
               32'((c == 0) || ((c >= 10) && (c <= 22) && ((c - 10) % 3 == 0))));
      end
      repeat (4) @(negedge r_clk);
      #1;
      check("empty_count_a", 32'(r_exp_a), 32'(16));
      check("empty_idle_a",  32'(w_m_valid_a), 32'(0));
`ifdef FIFO_RD_STATS_EN
      check("stat_rd_a",    32'(w_rd_count_a),    32'(6));
      check("stat_stall_a", 32'(w_stall_count_a), 32'(7));
`endif

      // Reset with a full buffer discards it; popping resumes at FIFO head
      @(posedge r_clk); #1;
      r_en = 1'b1; r_m_ready_b = 1'b0;
      for (int i = 5; i < 10; i++) r_mem_b[i] = 8'(8'h21 + (i - 5));
      r_tail_b = 10;
      repeat (3) @(negedge r_clk);
      check("full_valid_b", 32'(w_m_valid_b), 32'(1));
      check("full_rinc_b",  32'(w_rinc_b),    32'(0));
      check("full_head_b",  32'(w_m_data_b),  32'(8'h21));
      @(posedge r_clk); #1 r_rst = 1'b1;
      @(negedge r_clk);
      check("rstmid_rinc_b", 32'(w_rinc_b), 32'(0));
      @(posedge r_clk); #1 r_rst = 1'b0;
      @(negedge r_clk);
      check("rstmid_valid_b", 32'(w_m_valid_b), 32'(0));
      check("rstmid_data_b",  32'(w_m_data_b),  32'(0));
      check("rstmid_rinc_b1", 32'(w_rinc_b),    32'(1));
      check("rstmid_rdata_b", 32'(w_rdata_b),   32'(8'h23));
`ifdef FIFO_RD_STATS_EN
      check("rstmid_rdcnt_b", 32'(w_rd_count_b), 32'(0));
`endif
      @(posedge r_clk); #1 r_m_ready_b = 1'b1;
      repeat (6) @(negedge r_clk);
      #1;
      check("rstmid_count_b", 32'(r_exp_b), 32'(10));

      // Back-to-back stream 00..FF through the gap-0 instance
      @(posedge r_clk); #1;
      for (int k = 0; k < 256; k++) r_mem_b[10 + k] = 8'(k);
      r_tail_b = 266;
      for (int k = 0; k < 256; k++) begin
         @(negedge r_clk);
         check("stream_rinc_b", 32'(w_rinc_b), 32'(1));
      end
      repeat (3) @(negedge r_clk);
      #1;
      check("stream_count_b", 32'(r_exp_b), 32'(266));
      check("stream_idle_b",  32'(w_m_valid_b), 32'(0));
      check("stream_last_b",  32'(w_m_data_b),  32'(8'hFF));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
